// File: rtl/onchip_memory_master_if.sv
// Command, stream and Avalon-MM signal bundle for onchip_memory_master.
// The master modport is the mover's view; slave is the surrounding fabric's view.
interface onchip_memory_master_if;
  logic        cmd_start;
  logic        cmd_dir;
  logic [17:0] cmd_base;
  logic [17:0] cmd_len;
  logic        cmd_busy;
  logic        cmd_done;
  logic [31:0] snk_data;
  logic        snk_valid;
  logic        snk_ready;
  logic [31:0] src_data;
  logic        src_valid;
  logic        src_ready;
  logic [17:0] address;
  logic [3:0]  byteenable;
  logic        chipselect;
  logic        clken;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    input  cmd_start, cmd_dir, cmd_base, cmd_len, snk_data, snk_valid, src_ready, readdata,
    output cmd_busy, cmd_done, snk_ready, src_data, src_valid,
           address, byteenable, chipselect, clken, write, writedata
  );

  modport slave (
    output cmd_start, cmd_dir, cmd_base, cmd_len, snk_data, snk_valid, src_ready, readdata,
    input  cmd_busy, cmd_done, snk_ready, src_data, src_valid,
           address, byteenable, chipselect, clken, write, writedata
  );
endinterface

// File: rtl/onchip_memory_master.sv
// Avalon-MM block mover between a stream port and single-port on-chip RAM.
// Define ONCHIP_MEMORY_MASTER_BYTE_SWAP_EN to reverse byte order on both data paths.
module onchip_memory_master #(
  parameter int MEM_WORDS  = 256000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  onchip_memory_master_if.master bus
);
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, WR, RD, DRAIN, DONE} state_e;

  state_e        state_q, state_d;
  logic [17:0]   cur_q, cur_d, len_q, len_d, cnt_q, cnt_d;
  logic [17:0]   addr_q;
  logic          cs_q, we_q;
  logic [31:0]   wdata_q;
  logic [1:0]    rd_pipe_q;  // [0]: read on the bus, [1]: its readdata arrives this cycle
  logic [31:0]   fifo_q [FIFO_DEPTH];
  logic [PW-1:0] wp_q, rp_q;
  logic [PW:0]   count_q;
  logic [PW+1:0] occ;
  logic [17:0]   base_w;
  logic          beat, issue, push, pop;

  function automatic logic [31:0] swap(input logic [31:0] d);
`ifdef ONCHIP_MEMORY_MASTER_BYTE_SWAP_EN
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
    return d;
`endif
  endfunction

  function automatic logic [17:0] next_addr(input logic [17:0] a);
    return ({14'd0, a} >= 32'(MEM_WORDS - 1)) ? 18'd0 : a + 18'd1;
  endfunction

  assign base_w = ({14'd0, bus.cmd_base} >= 32'(MEM_WORDS)) ?
                  18'({14'd0, bus.cmd_base} - 32'(MEM_WORDS)) : bus.cmd_base;

  // Reads still in flight are counted as already occupying the FIFO so that
  // a stalled source can never overflow it.
  assign occ  = {1'b0, count_q} + (PW+2)'(rd_pipe_q[0]) + (PW+2)'(rd_pipe_q[1]);
  assign push = rd_pipe_q[1];
  assign pop  = (count_q != '0) && bus.src_ready;

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    beat    = 1'b0;
    issue   = 1'b0;
    unique case (state_q)
      IDLE: if (bus.cmd_start) begin
        cur_d = base_w;
        len_d = bus.cmd_len;
        cnt_d = '0;
        if (bus.cmd_len == '0) state_d = DONE;
        else                   state_d = bus.cmd_dir ? RD : WR;
      end
      WR: if (bus.snk_valid) begin
        beat  = 1'b1;
        cur_d = next_addr(cur_q);
        cnt_d = cnt_q + 18'd1;
        if (cnt_q + 18'd1 == len_q) state_d = DRAIN;
      end
      RD: if ((cnt_q < len_q) && (occ < (PW+2)'(FIFO_DEPTH))) begin
        issue = 1'b1;
        cur_d = next_addr(cur_q);
        cnt_d = cnt_q + 18'd1;
        if (cnt_q + 18'd1 == len_q) state_d = DRAIN;
      end
      // The final write drains through here too: it is on the bus during this cycle.
      DRAIN: if ((rd_pipe_q == 2'b00) && (count_q == '0)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cur_q     <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      addr_q    <= '0;
      cs_q      <= 1'b0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      rd_pipe_q <= '0;
      wp_q      <= '0;
      rp_q      <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      cs_q      <= beat | issue;
      we_q      <= beat;
      if (beat | issue) addr_q  <= cur_q;
      if (beat)         wdata_q <= swap(bus.snk_data);
      rd_pipe_q <= {rd_pipe_q[0], issue};
      if (push) wp_q <= wp_q + 1'b1;
      if (pop)  rp_q <= rp_q + 1'b1;
      count_q   <= count_q + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wp_q] <= swap(bus.readdata);
  end

  assign bus.cmd_busy   = (state_q != IDLE);
  assign bus.cmd_done   = (state_q == DONE);
  assign bus.snk_ready  = (state_q == WR);
  assign bus.src_valid  = (count_q != '0);
  assign bus.src_data   = (count_q != '0) ? fifo_q[rp_q] : 32'd0;
  assign bus.address    = addr_q;
  assign bus.chipselect = cs_q;
  assign bus.clken      = cs_q;
  assign bus.write      = we_q;
  assign bus.writedata  = wdata_q;
  assign bus.byteenable = {4{cs_q}};
endmodule
